rr_arbiter_nbit: RTL and testbench
==================================

# rr_arbiter_nbit

Round-robin arbiter that shares one resource between M = 2**N requesters and produces both a one-hot grant and its binary index. The index is the same N-bit encoding our n-bit encoder produces. Ownership is held across cycles until the owner releases or drops its request. An optional watchdog revokes grants held too long. The block sits in front of any shared datapath unit that requesters select by binary index.

## Interface
- N, default 2: index width; M = 2**N requesters.
- MAX_HOLD, default 15: maximum consecutive grant cycles before forced revoke; only used with watchdog; legal range 1..255.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  M  request per requester; level-sensitive.
- release  in  1  owner's single-cycle "done" pulse; ignored when no grant is active.
- grant  out  M  one-hot grant, registered; all zeros when idle.
- grant_idx  out  N  binary index of the owner, registered; holds its last value when idle.
- grant_valid  out  1  high while any grant is active; equals |grant.
- timeout  out  1  one-cycle pulse when the watchdog revokes a grant.

## Operation
- State machine has two states: IDLE and GRANT. Internal rotating pointer ptr is N bits wide.
- IDLE with req == 0: stay in IDLE; outputs unchanged.
- IDLE with req != 0: the winner is the first set bit at or above ptr, searched upward with wrap M-1 -> 0. On the next edge:
  - grant = onehot(winner), grant_idx = winner, grant_valid = 1.
  - State moves to GRANT.
- GRANT, release condition: release == 1 OR req[grant_idx] == 0. On the next edge:
  - grant = 0 and grant_valid = 0; grant_idx is unchanged.
  - ptr = (grant_idx + 1) mod M, with natural N-bit wrap.
  - State moves to IDLE.
- GRANT, no release: all outputs and ptr hold. New requests from other requesters are queued implicitly by their level; there is no preemption.
- Between owners there is always exactly one IDLE cycle with grant_valid = 0; back-to-back grants are not allowed.
- release in the same cycle as the owner's req deassertion counts as one release event.
- release pulses in IDLE have no effect and are not stored.
- Reset is asynchronous and may arrive at any time, including mid-grant. It forces:
  - state = IDLE, ptr = 0.
  - grant = 0, grant_idx = 0, grant_valid = 0, timeout = 0.
  - hold counter = 0.
- After rst_n deasserts, the first arbitration uses ptr = 0, so requester 0 has top priority.

## Timing
- Request-to-grant latency: 1 clock. req sampled at edge k gives grant visible after edge k+1 when in IDLE.
- Release-to-free latency: 1 clock. Release sampled at edge k gives grant = 0 after edge k+1.
- Next owner is granted at edge k+2.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- timeout is high for exactly the one cycle in which grant first reads 0 after a forced revoke.

## Configuration
- ARB_WATCHDOG_EN defined:
  - A hold counter of width $clog2(MAX_HOLD+1) clears on every entry to GRANT and increments each GRANT cycle.
  - When the counter reaches MAX_HOLD with no release, the next edge revokes the grant exactly like a release (same ptr advance) and pulses timeout.
  - A normal release in the same cycle as the limit takes precedence; no timeout pulse is generated.
- ARB_WATCHDOG_EN undefined:
  - No counter is built; grants persist indefinitely.
  - The timeout port exists and is tied to 0.

## Test plan
- Reset: hold rst_n = 0 with req = 4'b1111 -> grant = 0, grant_idx = 0, grant_valid = 0, timeout = 0. Assert rst_n = 0 asynchronously mid-grant -> outputs clear immediately, without waiting for a clock edge.
- Single requester (N = 2): req = 4'b0100 -> one edge later grant = 4'b0100, grant_idx = 2, grant_valid = 1. Output holds for 5 cycles; a release pulse -> grant = 0 on the next edge.
- Fairness: req = 4'b1111 held, each owner pulses release 2 cycles after being granted -> grant_idx sequence is 0, 1, 2, 3, 0, with exactly one grant_valid = 0 cycle between consecutive grants.
- Wrap and implicit release: after owner 3 is freed (ptr = 0), set req = 4'b1010 -> idx 1 is granted. Drop req[1] with no release -> grant clears on the next edge. Next grant is idx 3 (ptr = 2).
- Ignored release: pulse release while idle with req = 0 -> no state change. Then req = 4'b0001 -> grant to idx 0 after one edge.
- Watchdog (ARB_WATCHDOG_EN, MAX_HOLD = 4): req = 4'b0001 held, no release -> grant lasts exactly 4 cycles. Then grant = 0 with timeout = 1 for one cycle. One idle cycle later idx 0 is re-granted. Without the macro -> grant persists for 100+ cycles and timeout stays 0.

Source files
------------

// File: rtl/rr_arbiter_nbit.sv
// rr_arbiter_nbit
//   Round-robin arbiter sharing one resource between M = 2**N requesters.
//   Produces a registered one-hot grant plus its N-bit binary index. An owner
//   keeps the grant until it pulses owner_release or drops its request; the
//   pointer then advances to the requester just above the owner, and exactly
//   one idle cycle separates consecutive owners.
//
//   Optional feature: define ARB_WATCHDOG_EN to build a hold counter that
//   revokes a grant after MAX_HOLD consecutive cycles and pulses timeout.
//   Without it, grants persist indefinitely and timeout is tied to 0.
//
// Parameters
//   N         index width, M = 2**N requesters
//   MAX_HOLD  grant cycles before a forced revoke (watchdog only, 1..255)
//
// Ports
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   req[M]         level-sensitive requests
//   owner_release  owner's single-cycle done pulse ("release" is a reserved
//                  word, hence the longer name); ignored while idle
//   grant[M]       one-hot grant, zero when idle
//   grant_idx[N]   binary index of the owner, holds its last value when idle
//   grant_valid    |grant
//   timeout        one-cycle pulse in the first idle cycle after a revoke
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | no owner; arbitrate from ptr on any request
// GRANT | one owner holds the resource until release/req drop/revoke

module rr_arbiter_nbit #(
   parameter int N        = 2,
   parameter int MAX_HOLD = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [2**N-1:0]   req,
   input  logic              owner_release,
   output logic [2**N-1:0]   grant,
   output logic [N-1:0]      grant_idx,
   output logic              grant_valid,
   output logic              timeout
);

   localparam int M = 2**N;

   typedef enum logic {IDLE, GRANT} state_t;

   state_t          state, state_next;
   logic [N-1:0]    ptr, ptr_next;
   logic [M-1:0]    grant_next;
   logic [N-1:0]    idx_next;
   logic [N-1:0]    win;
   logic [N-1:0]    cand;
   logic            found;
   logic            rel_cond;
   logic            expire;

   // First set request at or above ptr, wrapping M-1 -> 0 through the
   // natural N-bit overflow of ptr + i.
   always_comb begin
      win   = '0;
      cand  = '0;
      found = 1'b0;
      for (int i = 0; i < M; i++) begin
         cand = ptr + N'(i);
         if (!found && req[cand]) begin
            win   = cand;
            found = 1'b1;
         end
      end
   end

   assign rel_cond = owner_release | ~req[grant_idx];

   always_comb begin
      state_next = state;
      ptr_next   = ptr;
      grant_next = grant;
      idx_next   = grant_idx;
      case (state)
         IDLE: begin
            if (found) begin
               grant_next = {{(M-1){1'b0}}, 1'b1} << win;
               idx_next   = win;
               state_next = GRANT;
            end
         end
         GRANT: begin
            if (rel_cond || expire) begin
               grant_next = '0;
               ptr_next   = grant_idx + 1'b1;
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
            grant_next = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         ptr       <= '0;
         grant     <= '0;
         grant_idx <= '0;
      end else begin
         state     <= state_next;
         ptr       <= ptr_next;
         grant     <= grant_next;
         grant_idx <= idx_next;
      end
   end

   assign grant_valid = |grant;

`ifdef ARB_WATCHDOG_EN
   localparam int HW = $clog2(MAX_HOLD + 1);

   logic [HW-1:0] hold_cnt;
   logic          timeout_q;

   // hold_cnt counts completed GRANT cycles before the current one, so the
   // limit is reached during the MAX_HOLD-th visible grant cycle and the
   // grant is seen for exactly MAX_HOLD cycles.
   assign expire = (state == GRANT) && (hold_cnt == HW'(MAX_HOLD - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_cnt  <= '0;
         timeout_q <= 1'b0;
      end else begin
         if (state == GRANT && state_next == GRANT)
            hold_cnt <= hold_cnt + 1'b1;
         else
            hold_cnt <= '0;
         // A real release in the limit cycle wins and suppresses the pulse.
         timeout_q <= expire && !rel_cond;
      end
   end

   assign timeout = timeout_q;
`else
   assign expire  = 1'b0;
   assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arbiter_nbit.sv
module tb_rr_arbiter_nbit;

   localparam int N = 2;
   localparam int M = 4;
`ifdef ARB_WATCHDOG_EN
   localparam int HOLD_ROWS = 3;
`else
   localparam int HOLD_ROWS = 4;
`endif

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [M-1:0]   req = '0;
   logic           rel = 1'b0;
   logic [M-1:0]   grant;
   logic [N-1:0]   grant_idx;
   logic           grant_valid;
   logic           timeout;

   rr_arbiter_nbit #(.N(N), .MAX_HOLD(4)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req           (req),
      .owner_release (rel),
      .grant         (grant),
      .grant_idx     (grant_idx),
      .grant_valid   (grant_valid),
      .timeout       (timeout)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] req;
      logic       rel;
      logic [3:0] g;
      logic [1:0] idx;
      logic       v;
   } vec_t;

   vec_t vecs[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check(string name, logic [31:0] got, logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic check_out(string tag, logic [3:0] g, logic [1:0] i, logic v, logic t);
      check({tag, " grant"},       32'(grant),       32'(g));
      check({tag, " grant_idx"},   32'(grant_idx),   32'(i));
      check({tag, " grant_valid"}, 32'(grant_valid), 32'(v));
      check({tag, " timeout"},     32'(timeout),     32'(t));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic void add(logic [3:0] r, logic l, logic [3:0] g, logic [1:0] i, logic v);
      vec_t e;
      e.req = r; e.rel = l; e.g = g; e.idx = i; e.v = v;
      vecs.push_back(e);
   endfunction

   initial begin
      // Reset held with all requests active
      req   = 4'b1111;
      rst_n = 1'b0;
      #12;
      check_out("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
      step();
      check_out("reset_edge", 4'b0000, 2'd0, 1'b0, 1'b0);
      rst_n = 1'b1;

      // Fairness: owners 0,1,2,3,0, release two cycles after grant
      for (int o = 0; o < 5; o++) begin
         add(4'b1111, 1'b0, 4'b0001 << (o % 4), 2'(o % 4), 1'b1);
         add(4'b1111, 1'b0, 4'b0001 << (o % 4), 2'(o % 4), 1'b1);
         add(4'b1111, 1'b1, 4'b0000,            2'(o % 4), 1'b0);
      end
      // ptr = 1: 1010 grants 1, drop req[1] -> implicit release, next is 3
      add(4'b1010, 1'b0, 4'b0010, 2'd1, 1'b1);
      add(4'b1000, 1'b0, 4'b0000, 2'd1, 1'b0);
      add(4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1);
      add(4'b1000, 1'b1, 4'b0000, 2'd3, 1'b0);
      // ptr = 0: release in idle is ignored
      add(4'b0000, 1'b1, 4'b0000, 2'd3, 1'b0);
      add(4'b0000, 1'b0, 4'b0000, 2'd3, 1'b0);
      add(4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1);
      add(4'b0001, 1'b1, 4'b0000, 2'd0, 1'b0);
      // ptr = 1: single requester 2 holds, then releases
      add(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1);
      for (int h = 0; h < HOLD_ROWS; h++)
         add(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1);
      add(4'b0100, 1'b1, 4'b0000, 2'd2, 1'b0);
      // ptr = 3: release together with req drop advances ptr only once
      add(4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1);
      add(4'b0000, 1'b1, 4'b0000, 2'd3, 1'b0);
      add(4'b0011, 1'b0, 4'b0001, 2'd0, 1'b1);
      add(4'b0011, 1'b1, 4'b0000, 2'd0, 1'b0);
      add(4'b0011, 1'b0, 4'b0010, 2'd1, 1'b1);
      add(4'b0000, 1'b0, 4'b0000, 2'd1, 1'b0);

      for (int k = 0; k < vecs.size(); k++) begin
         req = vecs[k].req;
         rel = vecs[k].rel;
         step();
         check_out($sformatf("vec%0d", k), vecs[k].g, vecs[k].idx, vecs[k].v, 1'b0);
      end
      rel = 1'b0;

      // Asynchronous reset mid-grant, then ptr restarts at 0
      req = 4'b0100;
      step();
      check_out("pre_async", 4'b0100, 2'd2, 1'b1, 1'b0);
      #3;
      rst_n = 1'b0;
      #1;
      check_out("async_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
      req = 4'b1111;
      step();
      rst_n = 1'b1;
      step();
      check_out("post_rst", 4'b0001, 2'd0, 1'b1, 1'b0);
      req = 4'b0000;
      step();
      check_out("post_rst_drop", 4'b0000, 2'd0, 1'b0, 1'b0);

      // Long hold of requester 0 (ptr = 1, search wraps to 0)
      req = 4'b0001;
      step();
      check_out("hold_c1", 4'b0001, 2'd0, 1'b1, 1'b0);
`ifdef ARB_WATCHDOG_EN
      for (int c = 2; c <= 4; c++) begin
         step();
         check_out($sformatf("wd_c%0d", c), 4'b0001, 2'd0, 1'b1, 1'b0);
      end
      step();
      check_out("wd_revoke", 4'b0000, 2'd0, 1'b0, 1'b1);
      step();
      check_out("wd_regrant", 4'b0001, 2'd0, 1'b1, 1'b0);
`else
      for (int c = 2; c <= 120; c++) begin
         step();
         check_out($sformatf("persist_c%0d", c), 4'b0001, 2'd0, 1'b1, 1'b0);
      end
`endif
      req = 4'b0000;
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
